mem_access_ctrl: RTL
====================

# mem_access_ctrl

Multicycle load/store sequencer between the CPU datapath and the synchronous data memory. It accepts one access per `start` pulse and handles word, halfword and byte loads and stores. Partial stores use a read-modify-write sequence. It returns a zero-extended load value and drives the datapath extension-unit selector so byte loads take the MDR path. It sits between the control FSM (which issues `start` and waits for `done`) and the memory/MDR.

## Interface
- `MEM_LAT`, default 1: memory read latency in cycles (0 = combinational read); legal range 0..7.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; forces idle state and reset output values immediately.
- `start`  in  1  request pulse; sampled only in IDLE.
- `op`  in  3  000 LW, 001 LH, 010 LB, 100 SW, 101 SH, 110 SB; other codes are illegal.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data; the low 8/16 bits are used for SB/SH.
- `mem_addr`  out  32  word-aligned address `{addr[31:2],2'b00}`.
- `mem_wr`  out  1  memory write strobe, one cycle.
- `mem_wdata`  out  32  full word to write.
- `mem_rdata`  in  32  memory read word.
- `rdata`  out  32  load result, zero-extended; held until the next accepted request.
- `ext_sel`  out  1  extension-unit selector: 1 when the last completed op was LB, else 0; held like `rdata`.
- `busy`  out  1  high from the cycle after acceptance through the DONE cycle.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`; marks a misaligned access or illegal op.

## Operation
- Byte order is little-endian: byte offset k occupies `[8k+7:8k]`; halfword offset h (0 or 2) occupies `[8h+15:8h]`.
- On acceptance (IDLE, `start`=1), `op`, `addr` and `wdata` are latched. Later changes on these inputs have no effect.
- Error check at acceptance:
  - illegal op → error;
  - LW/SW with `addr[1:0]`≠0 → error;
  - LH/SH with `addr[0]`≠0 → error.
  - On error: go directly to DONE with `err`=1. No memory access occurs and `rdata` is unchanged.
- State machine:
  - IDLE → RD for loads, SH and SB; IDLE → WR for SW; IDLE → DONE on error.
  - RD lasts MEM_LAT+1 cycles, counted by an internal counter. `mem_addr` is stable and `mem_wr`=0 throughout. `mem_rdata` is captured into an internal buffer at the edge ending the last RD cycle.
  - RD → DONE for loads.
  - RD → WR for SH/SB, with `mem_wdata` = captured word with the selected lane replaced by `wdata[7:0]` or `wdata[15:0]`.
  - WR lasts one cycle with `mem_wr`=1. SW writes `wdata` unmodified. WR → DONE.
  - DONE lasts one cycle with `done`=1, then returns to IDLE.
- On the RD→DONE edge, `rdata` is loaded from the captured word:
  - LW: the full word;
  - LH: `{16'b0, lane}`;
  - LB: `{24'b0, lane}`.
  - `ext_sel` updates on the same edge (1 for LB, else 0).
- Outside RD and WR, `mem_addr`=0, `mem_wdata`=0 and `mem_wr`=0.
- A `start` while busy is ignored and not queued.

## Timing
- Reset values: `mem_addr`, `mem_wdata`, `rdata` = 0; `mem_wr`, `busy`, `done`, `err`, `ext_sel` = 0; state IDLE; counter 0.
- Start accepted at edge E0. `busy` rises after E0. `done` is high in cycle N after E0:
  - loads: N = MEM_LAT+2;
  - SW: N = 2;
  - SH/SB: N = MEM_LAT+3;
  - error: N = 1.
- `start` may be re-asserted in the cycle after DONE. Back-to-back throughput is therefore N+1 cycles per access.
- A new request can be accepted in the cycle after DONE; there is no acceptance in the DONE cycle itself.
- Reset mid-operation: all outputs drop to their reset values immediately (asynchronously), including `mem_wr` in WR. An interrupted write is abandoned and no `done` is produced.

## Structure
- Shared package `mem_ctrl_pkg`: op encodings (`OP_LW`…`OP_SB`), state encoding (IDLE, RD, WR, DONE), and the `MEM_LAT` counter width (3 bits).
- Sub-module `mem_lane_unit` (combinational): given word, offset, size and store data, produces the extracted zero-extended load value and the merged store word. It is instantiated once.
- Top-level holds the FSM, latency counter, input latches and result registers.

## Test plan
- Reset during RD with `start` pending → all outputs 0 immediately; after release, the held `start` is accepted normally.
- LW, MEM_LAT=1, `addr`=0x10, memory word 0xDEADBEEF → `done` in cycle 3; `rdata`=0xDEADBEEF; `ext_sel`=0; `err`=0.
- LB, `addr`=0x13, word 0xA1B2C3D4 → `rdata`=0x000000A1, `ext_sel`=1. LH, `addr`=0x12 → `rdata`=0x0000A1B2.
- SB, `addr`=0x21, `wdata`=0x000000EE, old word 0x11223344 → single `mem_wr` cycle with `mem_addr`=0x20, `mem_wdata`=0x1122EE44; `done` in cycle 4.
- LW `addr`=0x02, SH `addr`=0x03, op=011 → each gives `done`=1 with `err`=1 in cycle 1, no `mem_wr`, `rdata` unchanged.
- `start` pulsed during busy SW, then MEM_LAT=0 LW → the busy-time `start` is ignored; the LW completes in cycle 2.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the load/store sequencer: op codes, FSM states,
// access sizes and small decode helpers used at request acceptance.
package mem_ctrl_pkg;

    localparam int CNT_W = 3;

    localparam logic [2:0] OP_LW = 3'b000;
    localparam logic [2:0] OP_LH = 3'b001;
    localparam logic [2:0] OP_LB = 3'b010;
    localparam logic [2:0] OP_SW = 3'b100;
    localparam logic [2:0] OP_SH = 3'b101;
    localparam logic [2:0] OP_SB = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } size_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op inside {OP_LW, OP_LH, OP_LB, OP_SW, OP_SH, OP_SB};
    endfunction

    function automatic logic op_is_store(input logic [2:0] op);
        return op[2];
    endfunction

    // Loads and stores share the low two op bits for the access size.
    function automatic size_e op_size(input logic [1:0] code);
        case (code)
            2'b00:   return SZ_WORD;
            2'b01:   return SZ_HALF;
            default: return SZ_BYTE;
        endcase
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_WORD: return off != 2'b00;
            SZ_HALF: return off[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Little-endian lane logic: extracts a zero-extended load value from a word
// and merges store data into the selected byte/halfword lane.
module mem_lane_unit
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  size_e       size,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        load_data  = word;
        store_word = store_data;
        case (size)
            SZ_HALF: begin
                load_data  = {16'b0, word[{offset[1], 4'b0000} +: 16]};
                store_word = word;
                store_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
            end
            SZ_BYTE: begin
                load_data  = {24'b0, word[{offset, 3'b000} +: 8]};
                store_word = word;
                store_word[{offset, 3'b000} +: 8] = store_data[7:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multicycle load/store sequencer between the CPU datapath and a synchronous
// data memory; partial stores are done as read-modify-write.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] rdata,
    output logic        ext_sel,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         op_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic               err_q;
    logic [31:0]        word_q;

    logic               req_err;
    logic               rd_last;
    logic [31:0]        lane_word;
    logic [31:0]        load_val;
    logic [31:0]        merged;

    assign req_err = !op_is_legal(op) || misaligned(op_size(op[1:0]), addr[1:0]);
    assign rd_last = (state_q == ST_RD) && (cnt_q == LAT_LAST);

    // Loads extract straight from the bus on the capturing edge; RMW merges
    // into the word captured at the end of RD.
    assign lane_word = (state_q == ST_WR) ? word_q : mem_rdata;

    mem_lane_unit u_lane (
        .word       (lane_word),
        .offset     (addr_q[1:0]),
        .size       (op_size(op_q[1:0])),
        .store_data (wdata_q),
        .load_data  (load_val),
        .store_word (merged)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (req_err)           state_d = ST_DONE;
                    else if (op == OP_SW)  state_d = ST_WR;
                    else                   state_d = ST_RD;
                end
            end
            ST_RD: begin
                if (rd_last) state_d = op_is_store(op_q) ? ST_WR : ST_DONE;
            end
            ST_WR:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory-side outputs decode from state so reset clears them at once.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr    = 1'b0;
        if (state_q == ST_RD || state_q == ST_WR) mem_addr = {addr_q[31:2], 2'b00};
        if (state_q == ST_WR) begin
            mem_wr    = 1'b1;
            mem_wdata = merged;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign err  = (state_q == ST_DONE) && err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            word_q  <= '0;
            rdata   <= '0;
            ext_sel <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            if (state_q == ST_RD && !rd_last) cnt_q <= cnt_q + 1'b1;
            else                              cnt_q <= '0;
            if (state_q == ST_IDLE && start) begin
                op_q    <= op;
                addr_q  <= addr;
                wdata_q <= wdata;
                err_q   <= req_err;
            end
            if (rd_last) begin
                word_q <= mem_rdata;
                if (!op_is_store(op_q)) begin
                    rdata   <= load_val;
                    ext_sel <= (op_q == OP_LB);
                end
            end
        end
    end

endmodule
